// File: rtl/keypad_pkg.sv
// Shared constants, types and hit-test helpers for the on-screen keypad decoder.
package keypad_pkg;

    localparam logic [3:0] KEY_NONE = 4'd15;
    localparam logic [3:0] KEY_C    = 4'd10;
    localparam logic [3:0] KEY_M    = 4'd11;

    localparam int NUM_ROWS = 4;
    localparam int NUM_COLS = 3;

    localparam int unsigned GLYPH_W = 16;
    localparam int unsigned GLYPH_H = 32;

    localparam int unsigned COL_X [NUM_COLS] = '{515, 621, 728};
    localparam int unsigned ROW_Y [NUM_ROWS] = '{174, 254, 334, 414};

    localparam logic [3:0] KEY_MAP [NUM_ROWS][NUM_COLS] = '{
        '{4'd1, 4'd2, 4'd3},
        '{4'd4, 4'd5, 4'd6},
        '{4'd7, 4'd8, 4'd9},
        '{KEY_C, 4'd0, KEY_M}
    };

    typedef enum logic {IDLE, HELD} kp_state_e;

    typedef struct packed {
        logic [3:0] code;
        logic       press;
    } key_evt_t;

    // Half-open span [origin-margin, origin+size+margin), lower bound clamped at 0.
    function automatic logic in_span(logic [11:0] v, int unsigned origin, int unsigned size,
                                     int unsigned margin);
        logic [12:0] lo;
        logic [12:0] hi;
        logic [12:0] v13;
        v13 = {1'b0, v};
        lo  = (origin > margin) ? 13'(origin - margin) : 13'd0;
        hi  = 13'(origin + size + margin);
        return (v13 >= lo) && (v13 < hi);
    endfunction

    function automatic logic [3:0] classify(logic down, logic [11:0] x, logic [11:0] y,
                                            int unsigned margin);
        logic [3:0] code;
        code = KEY_NONE;
        if (down) begin
            for (int r = 0; r < NUM_ROWS; r++) begin
                for (int c = 0; c < NUM_COLS; c++) begin
                    if (in_span(x, COL_X[c], GLYPH_W, margin) &&
                        in_span(y, ROW_Y[r], GLYPH_H, margin)) begin
                        code = KEY_MAP[r][c];
                    end
                end
            end
        end
        return code;
    endfunction

endpackage

// File: rtl/keypad_hit_decoder_if.sv
// Pointer-sample input and key-event output bundle of the keypad decoder.
interface keypad_hit_decoder_if;

    logic        pt_valid;
    logic        pt_down;
    logic [11:0] pt_x;
    logic [11:0] pt_y;
    logic        key_valid;
    logic        key_ready;
    logic [3:0]  key_code;
    logic        key_press;
    logic [3:0]  cur_key;
    logic        evt_overflow;

    modport master (
        output pt_valid, pt_down, pt_x, pt_y, key_ready,
        input  key_valid, key_code, key_press, cur_key, evt_overflow
    );

    modport slave (
        input  pt_valid, pt_down, pt_x, pt_y, key_ready,
        output key_valid, key_code, key_press, cur_key, evt_overflow
    );

endinterface

// File: rtl/keypad_evt_fifo.sv
// Show-ahead event FIFO; only compiled when KEYPAD_EVT_FIFO_EN is defined.
`ifdef KEYPAD_EVT_FIFO_EN
module keypad_evt_fifo
    import keypad_pkg::*;
#(
    parameter int unsigned Depth = 4
) (
    input  logic     clk_i,
    input  logic     rst_i,
    input  logic     push_valid_i,
    input  key_evt_t push_data_i,
    output logic     pop_valid_o,
    input  logic     pop_ready_i,
    output key_evt_t pop_data_o,
    output logic     full_o,
    output logic     empty_o
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

    key_evt_t        mem_q [Depth];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PtrW:0]   count_q, count_d;
    logic            do_push;
    logic            do_pop;

    assign empty_o     = (count_q == '0);
    assign full_o      = (count_q == (PtrW + 1)'(Depth));
    assign pop_valid_o = !empty_o;
    assign pop_data_o  = mem_q[rd_ptr_q];
    assign do_pop      = pop_ready_i && !empty_o;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign do_push     = push_valid_i && (!full_o || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PtrW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (PtrW + 1)'(1);
            2'b01:   count_d = count_q - (PtrW + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data_i;
    end

endmodule
`endif

// File: rtl/keypad_hit_decoder.sv
// Touch/pointer samples to debounced 4x3 keypad press/release events.
// Define KEYPAD_EVT_FIFO_EN to replace the single event register with a 4-deep FIFO.
module keypad_hit_decoder
    import keypad_pkg::*;
#(
    parameter int unsigned MARGIN     = 24,
    parameter int unsigned STABLE_CNT = 4
) (
    input logic                 pclk,
    input logic                 rst,
    keypad_hit_decoder_if.slave kp
);

    localparam logic [7:0] StableMax = 8'(STABLE_CNT);

    logic [3:0] class_q, class_d;
    logic       class_vld_q;
    logic [3:0] cand_q, cand_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] cnt_base;
    logic       stable;

    kp_state_e  state_q, state_d;
    logic [3:0] cur_key_q, cur_key_d;
    logic       evt_push;
    key_evt_t   evt_data;
    logic       release_evt;

    logic       ovf_q, ovf_d;
    logic       evt_drop;

    assign class_d = kp.pt_valid ? classify(kp.pt_down, kp.pt_x, kp.pt_y, MARGIN) : class_q;
    assign stable  = (cnt_q == StableMax);

    // A release clears the count first; a sample landing the same cycle then counts from zero.
    always_comb begin
        cnt_base = release_evt ? 8'd0 : cnt_q;
        cand_d   = cand_q;
        cnt_d    = cnt_base;
        if (class_vld_q) begin
            if (class_q != cand_q) begin
                cand_d = class_q;
                cnt_d  = 8'd1;
            end else if (cnt_base < StableMax) begin
                cnt_d = cnt_base + 8'd1;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        cur_key_d   = cur_key_q;
        evt_push    = 1'b0;
        evt_data    = '{code: KEY_NONE, press: 1'b0};
        release_evt = 1'b0;
        case (state_q)
            IDLE: begin
                if (stable && (cand_q != KEY_NONE)) begin
                    evt_push  = 1'b1;
                    evt_data  = '{code: cand_q, press: 1'b1};
                    cur_key_d = cand_q;
                    state_d   = HELD;
                end
            end
            HELD: begin
                if (stable && (cand_q != cur_key_q)) begin
                    evt_push    = 1'b1;
                    evt_data    = '{code: cur_key_q, press: 1'b0};
                    cur_key_d   = KEY_NONE;
                    release_evt = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            class_q     <= KEY_NONE;
            class_vld_q <= 1'b0;
            cand_q      <= KEY_NONE;
            cnt_q       <= 8'd0;
            state_q     <= IDLE;
            cur_key_q   <= KEY_NONE;
            ovf_q       <= 1'b0;
        end else begin
            class_q     <= class_d;
            class_vld_q <= kp.pt_valid;
            cand_q      <= cand_d;
            cnt_q       <= cnt_d;
            state_q     <= state_d;
            cur_key_q   <= cur_key_d;
            ovf_q       <= ovf_d;
        end
    end

`ifdef KEYPAD_EVT_FIFO_EN
    key_evt_t fifo_head;
    logic     fifo_full;
    logic     fifo_empty;

    keypad_evt_fifo #(
        .Depth(4)
    ) u_evt_fifo (
        .clk_i       (pclk),
        .rst_i       (rst),
        .push_valid_i(evt_push),
        .push_data_i (evt_data),
        .pop_valid_o (kp.key_valid),
        .pop_ready_i (kp.key_ready),
        .pop_data_o  (fifo_head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    assign evt_drop     = evt_push && fifo_full && !kp.key_ready;
    assign kp.key_code  = fifo_empty ? KEY_NONE : fifo_head.code;
    assign kp.key_press = !fifo_empty && fifo_head.press;
`else
    logic     sink_valid_q, sink_valid_d;
    key_evt_t sink_evt_q, sink_evt_d;

    assign evt_drop = evt_push && sink_valid_q && !kp.key_ready;

    always_comb begin
        sink_valid_d = sink_valid_q;
        sink_evt_d   = sink_evt_q;
        if (sink_valid_q && kp.key_ready) sink_valid_d = 1'b0;
        if (evt_push && !evt_drop) begin
            sink_valid_d = 1'b1;
            sink_evt_d   = evt_data;
        end
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            sink_valid_q <= 1'b0;
            sink_evt_q   <= '{code: KEY_NONE, press: 1'b0};
        end else begin
            sink_valid_q <= sink_valid_d;
            sink_evt_q   <= sink_evt_d;
        end
    end

    assign kp.key_valid = sink_valid_q;
    assign kp.key_code  = sink_evt_q.code;
    assign kp.key_press = sink_evt_q.press;
`endif

    assign ovf_d           = ovf_q | evt_drop;
    assign kp.cur_key      = cur_key_q;
    assign kp.evt_overflow = ovf_q;

endmodule

// File: tb/tb_keypad_hit_decoder.sv
// Directed bench for keypad_hit_decoder: latency, debounce, hit-box edges, slide, backpressure, reset.
module tb_keypad_hit_decoder;

    localparam logic [3:0] NONE = 4'd15;

    logic pclk;
    logic rst;
    int   n_vec;
    int   n_err;
    logic [4:0] obs_q [$];

    keypad_hit_decoder_if kp ();

    keypad_hit_decoder #(
        .MARGIN    (24),
        .STABLE_CNT(4)
    ) dut (
        .pclk(pclk),
        .rst (rst),
        .kp  (kp)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    // Log every accepted event just before the edge that completes the handshake.
    always @(negedge pclk) begin
        if (!rst && kp.key_valid && kp.key_ready) obs_q.push_back({kp.key_code, kp.key_press});
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge pclk);
            #1;
        end
    endtask

    task automatic send(input logic down, input int x, input int y);
        kp.pt_valid = 1'b1;
        kp.pt_down  = down;
        kp.pt_x     = 12'(x);
        kp.pt_y     = 12'(y);
        @(posedge pclk);
        #1;
        kp.pt_valid = 1'b0;
    endtask

    task automatic expect_evt(input string tag, input logic [3:0] code, input logic press);
        logic [4:0] got;
        check_val({tag, "_avail"}, 32'(obs_q.size() != 0), 32'd1);
        if (obs_q.size() != 0) begin
            got = obs_q.pop_front();
            check_val(tag, 32'(got), 32'({code, press}));
        end
    endtask

    task automatic probe(input string tag, input int x, input int y, input logic [3:0] exp);
        repeat (4) send(1'b1, x, y);
        idle(3);
        check_val({tag, "_held"}, 32'(kp.cur_key), 32'(exp));
        repeat (4) send(1'b0, x, y);
        idle(3);
        if (exp != NONE) begin
            expect_evt({tag, "_press"}, exp, 1'b1);
            expect_evt({tag, "_rel"}, exp, 1'b0);
        end
        check_val({tag, "_drained"}, 32'(obs_q.size()), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want $finish");
        $fatal(1);
    end

    initial begin
        n_vec       = 0;
        n_err       = 0;
        rst         = 1'b1;
        kp.pt_valid = 1'b0;
        kp.pt_down  = 1'b0;
        kp.pt_x     = 12'd0;
        kp.pt_y     = 12'd0;
        kp.key_ready = 1'b1;
        idle(2);
        check_val("rst_valid", 32'(kp.key_valid), 32'd0);
        check_val("rst_code", 32'(kp.key_code), 32'(NONE));
        check_val("rst_press", 32'(kp.key_press), 32'd0);
        check_val("rst_cur", 32'(kp.cur_key), 32'(NONE));
        check_val("rst_ovf", 32'(kp.evt_overflow), 32'd0);
        rst = 1'b0;
        idle(1);

        // Press/release with exact E+2 latency
        repeat (4) send(1'b1, 520, 180);
        check_val("pr_lat_e0", 32'(kp.key_valid), 32'd0);
        idle(1);
        check_val("pr_lat_e1", 32'(kp.key_valid), 32'd0);
        check_val("pr_cur_e1", 32'(kp.cur_key), 32'(NONE));
        idle(1);
        check_val("pr_lat_e2", 32'(kp.key_valid), 32'd1);
        check_val("pr_code", 32'(kp.key_code), 32'd1);
        check_val("pr_press", 32'(kp.key_press), 32'd1);
        check_val("pr_cur", 32'(kp.cur_key), 32'd1);
        repeat (4) send(1'b0, 520, 180);
        idle(2);
        check_val("rl_valid", 32'(kp.key_valid), 32'd1);
        check_val("rl_code", 32'(kp.key_code), 32'd1);
        check_val("rl_press", 32'(kp.key_press), 32'd0);
        check_val("rl_cur", 32'(kp.cur_key), 32'(NONE));
        idle(2);
        expect_evt("pr_evt", 4'd1, 1'b1);
        expect_evt("rl_evt", 4'd1, 1'b0);

        // Bounce never settles
        for (int i = 0; i < 10; i++) send((i % 2) == 0, 625, 260);
        idle(4);
        check_val("bounce_events", 32'(obs_q.size()), 32'd0);
        check_val("bounce_cur", 32'(kp.cur_key), 32'(NONE));

        // Hit-box boundaries
        probe("m_left_in", 491, 150, 4'd1);
        probe("m_left_out", 490, 150, NONE);
        probe("m_bot_in", 735, 469, 4'd11);
        probe("m_bot_out", 735, 470, NONE);
        probe("m_right_in", 767, 200, 4'd3);
        probe("m_right_out", 768, 200, NONE);
        probe("m_key0", 630, 420, 4'd0);

        // Direct slide 7 -> 8
        repeat (4) send(1'b1, 520, 340);
        repeat (8) send(1'b1, 625, 340);
        idle(3);
        check_val("slide_cur", 32'(kp.cur_key), 32'd8);
        repeat (4) send(1'b0, 625, 340);
        idle(3);
        expect_evt("slide_p7", 4'd7, 1'b1);
        expect_evt("slide_r7", 4'd7, 1'b0);
        expect_evt("slide_p8", 4'd8, 1'b1);
        expect_evt("slide_r8", 4'd8, 1'b0);

        // Backpressure
        kp.key_ready = 1'b0;
        repeat (4) send(1'b1, 625, 180);
        idle(3);
        check_val("bp_valid", 32'(kp.key_valid), 32'd1);
        check_val("bp_code", 32'(kp.key_code), 32'd2);
        check_val("bp_press", 32'(kp.key_press), 32'd1);
        check_val("bp_ovf0", 32'(kp.evt_overflow), 32'd0);
        repeat (4) send(1'b0, 625, 180);
        idle(3);
        check_val("bp_cur", 32'(kp.cur_key), 32'(NONE));
        check_val("bp_hold_code", 32'(kp.key_code), 32'd2);
        check_val("bp_hold_press", 32'(kp.key_press), 32'd1);
`ifdef KEYPAD_EVT_FIFO_EN
        check_val("bp_ovf_q2", 32'(kp.evt_overflow), 32'd0);
        repeat (4) send(1'b1, 735, 180);
        repeat (4) send(1'b0, 735, 180);
        idle(3);
        check_val("bp_ovf_q4", 32'(kp.evt_overflow), 32'd0);
        repeat (4) send(1'b1, 735, 260);
        idle(3);
        check_val("bp_ovf_q5", 32'(kp.evt_overflow), 32'd1);
        check_val("bp_cur6", 32'(kp.cur_key), 32'd6);
        kp.key_ready = 1'b1;
        idle(6);
        expect_evt("bp_p2", 4'd2, 1'b1);
        expect_evt("bp_r2", 4'd2, 1'b0);
        expect_evt("bp_p3", 4'd3, 1'b1);
        expect_evt("bp_r3", 4'd3, 1'b0);
        repeat (4) send(1'b0, 735, 260);
        idle(3);
        expect_evt("bp_r6", 4'd6, 1'b0);
`else
        check_val("bp_ovf1", 32'(kp.evt_overflow), 32'd1);
        kp.key_ready = 1'b1;
        idle(1);
        check_val("bp_drained", 32'(kp.key_valid), 32'd0);
        expect_evt("bp_p2", 4'd2, 1'b1);
`endif
        check_val("bp_empty", 32'(obs_q.size()), 32'd0);

        // Reset while M is held with its press still pending
        kp.key_ready = 1'b0;
        repeat (4) send(1'b1, 735, 430);
        idle(3);
        check_val("rh_cur", 32'(kp.cur_key), 32'd11);
        check_val("rh_pend", 32'(kp.key_valid), 32'd1);
        check_val("rh_code", 32'(kp.key_code), 32'd11);
        rst = 1'b1;
        idle(1);
        check_val("rh_valid", 32'(kp.key_valid), 32'd0);
        check_val("rh_code0", 32'(kp.key_code), 32'(NONE));
        check_val("rh_press0", 32'(kp.key_press), 32'd0);
        check_val("rh_cur0", 32'(kp.cur_key), 32'(NONE));
        check_val("rh_ovf0", 32'(kp.evt_overflow), 32'd0);
        rst = 1'b0;
        kp.key_ready = 1'b1;
        repeat (4) send(1'b0, 735, 430);
        idle(4);
        check_val("rh_no_release", 32'(obs_q.size()), 32'd0);
        check_val("rh_valid_after", 32'(kp.key_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
